// File: rtl/afe_inj_sequencer.sv
// Injection-scan controller: emits a programmable train of injection pulses and
// measures each pulse's synchronized comparator time-over-threshold and hit flag.
module afe_inj_sequencer #(
  parameter int CNT_W = 16,
  parameter int TOT_W = 8,
  parameter int SUM_W = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] N_INJ,
  input  logic [CNT_W-1:0] T_HIGH,
  input  logic [CNT_W-1:0] T_PERIOD,
  input  logic             COMP,
  output logic             INJ_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] HIT_COUNT,
  output logic [SUM_W-1:0] TOT_SUM,
  output logic [TOT_W-1:0] TOT_LAST,
  output logic [CNT_W-1:0] INJ_COUNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_th;
  logic [CNT_W-1:0] r_tl;
  logic [CNT_W-1:0] r_phase;
  logic             r_inj;

  logic             r_comp_meta;
  logic             r_comp_s;
  logic             r_inj_d1;
  logic             r_win;
  logic [TOT_W-1:0] r_tot;
  logic             r_hit;

  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_inj_count;
  logic [SUM_W-1:0] r_tot_sum;
  logic [TOT_W-1:0] r_tot_last;

  logic [CNT_W-1:0] w_th_in;
  logic [CNT_W-1:0] w_tl_in;
  logic [CNT_W:0]   w_th_plus3;
  logic             w_abort;
  logic             w_start;
  logic             w_phase_end;
  logic             w_eval;
  logic             w_more;
  logic             w_enter_high;
  logic [SUM_W:0]   w_sum_ext;

  // Low time is clamped to 3 so the delayed window always closes before evaluation.
  assign w_th_in      = (T_HIGH == '0) ? CNT_W'(1) : T_HIGH;
  assign w_th_plus3   = {1'b0, w_th_in} + (CNT_W+1)'(3);
  assign w_tl_in      = ({1'b0, T_PERIOD} >= w_th_plus3) ? (T_PERIOD - w_th_in) : CNT_W'(3);

  assign w_abort      = ABORT && (r_state != S_IDLE);
  assign w_start      = (r_state == S_IDLE) && START && !ABORT && (N_INJ != '0);
  assign w_phase_end  = (r_phase == '0);
  assign w_eval       = (r_state == S_LOW) && w_phase_end && !ABORT;
  assign w_more       = ({1'b0, r_inj_count} + (CNT_W+1)'(1)) < {1'b0, r_n};
  assign w_enter_high = w_start || (w_eval && w_more);
  assign w_sum_ext    = {1'b0, r_tot_sum} + (SUM_W+1)'(r_tot);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_th    <= '0;
      r_tl    <= '0;
      r_phase <= '0;
      r_inj   <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_inj   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_HIGH;
            r_n     <= N_INJ;
            r_th    <= w_th_in;
            r_tl    <= w_tl_in;
            r_phase <= w_th_in - CNT_W'(1);
            r_inj   <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_state <= S_LOW;
            r_phase <= r_tl - CNT_W'(1);
            r_inj   <= 1'b0;
          end else begin
            r_phase <= r_phase - CNT_W'(1);
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            if (w_more) begin
              r_state <= S_HIGH;
              r_phase <= r_th - CNT_W'(1);
              r_inj   <= 1'b1;
            end else begin
              r_state <= S_FIN;
            end
          end else begin
            r_phase <= r_phase - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The window is INJ delayed by two cycles so it lines up with the synchronized COMP.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_comp_meta <= 1'b0;
      r_comp_s    <= 1'b0;
      r_inj_d1    <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_comp_meta <= COMP;
      r_comp_s    <= r_comp_meta;
      r_inj_d1    <= r_inj;
      r_win       <= r_inj_d1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tot <= '0;
      r_hit <= 1'b0;
    end else if (w_enter_high) begin
      r_tot <= '0;
      r_hit <= 1'b0;
    end else if (r_win && r_comp_s) begin
      r_hit <= 1'b1;
      if (r_tot != '1) begin
        r_tot <= r_tot + TOT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || w_start) begin
      r_hit_count <= '0;
      r_inj_count <= '0;
      r_tot_sum   <= '0;
      r_tot_last  <= '0;
    end else if (w_eval) begin
      r_inj_count <= r_inj_count + CNT_W'(1);
      if (r_hit) begin
        r_hit_count <= r_hit_count + CNT_W'(1);
        r_tot_last  <= r_tot;
        r_tot_sum   <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
      end else begin
        r_tot_last  <= '0;
      end
    end
  end

  assign INJ_OUT   = r_inj;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_FIN);
  assign HIT_COUNT = r_hit_count;
  assign TOT_SUM   = r_tot_sum;
  assign TOT_LAST  = r_tot_last;
  assign INJ_COUNT = r_inj_count;

endmodule

// File: tb/tb_afe_inj_sequencer.sv
// Directed bench for afe_inj_sequencer: table of pulse trains plus hand-written
// abort, reset and ignored-request sequences. TOT accumulator is narrowed to 10 bits.
module tb_afe_inj_sequencer;

  localparam int CNT_W = 16;
  localparam int TOT_W = 8;
  localparam int SUM_W = 10;

  logic             CLK;
  logic             RESET;
  logic             START;
  logic             ABORT;
  logic [CNT_W-1:0] N_INJ;
  logic [CNT_W-1:0] T_HIGH;
  logic [CNT_W-1:0] T_PERIOD;
  logic             COMP;
  logic             INJ_OUT;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] HIT_COUNT;
  logic [SUM_W-1:0] TOT_SUM;
  logic [TOT_W-1:0] TOT_LAST;
  logic [CNT_W-1:0] INJ_COUNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    int th;
    int tper;
    int mode;
    int thEff;
    int pEff;
    int expHits;
    int expSum;
    int expLast;
  } vec_t;

  vec_t vecs[6];

  afe_inj_sequencer #(.CNT_W(CNT_W), .TOT_W(TOT_W), .SUM_W(SUM_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .N_INJ(N_INJ), .T_HIGH(T_HIGH), .T_PERIOD(T_PERIOD), .COMP(COMP),
    .INJ_OUT(INJ_OUT), .BUSY(BUSY), .DONE(DONE), .HIT_COUNT(HIT_COUNT),
    .TOT_SUM(TOT_SUM), .TOT_LAST(TOT_LAST), .INJ_COUNT(INJ_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // mode 0: COMP low; mode 1: COMP high at offsets 2..5 of each period; mode 2: COMP high
  function automatic logic compAt(input vec_t v, input int c);
    int off;
    if (v.mode == 2) return 1'b1;
    if (v.mode == 0 || c < 1 || c > v.n * v.pEff) return 1'b0;
    off = (c - 1) % v.pEff;
    return (off >= 2 && off <= 5);
  endfunction

  task automatic applyStimulus(input int idx, input vec_t v);
    int np;
    int waveErr;
    int busyErr;
    int firstDone;
    int doneCount;
    logic expInj;
    np = v.n * v.pEff;
    waveErr = 0;
    busyErr = 0;
    firstDone = 0;
    doneCount = 0;
    N_INJ    = CNT_W'(v.n);
    T_HIGH   = CNT_W'(v.th);
    T_PERIOD = CNT_W'(v.tper);
    START    = 1'b1;
    COMP     = compAt(v, 0);
    for (int c = 1; c <= np + 2; c++) begin
      tick();
      expInj = (c <= np) && (((c - 1) % v.pEff) < v.thEff);
      if (INJ_OUT !== expInj) waveErr++;
      if (BUSY !== (c <= np + 1)) busyErr++;
      if (DONE === 1'b1) begin
        doneCount++;
        if (firstDone == 0) firstDone = c;
      end
      START = 1'b0;
      COMP  = compAt(v, c);
    end
    COMP = 1'b0;
    checkOutput($sformatf("v%0d inj_wave_errs", idx), waveErr, 0);
    checkOutput($sformatf("v%0d busy_errs", idx), busyErr, 0);
    checkOutput($sformatf("v%0d done_cycle", idx), firstDone, np + 1);
    checkOutput($sformatf("v%0d done_count", idx), doneCount, 1);
    checkOutput($sformatf("v%0d inj_count", idx), int'(INJ_COUNT), v.n);
    checkOutput($sformatf("v%0d hit_count", idx), int'(HIT_COUNT), v.expHits);
    checkOutput($sformatf("v%0d tot_sum", idx), int'(TOT_SUM), v.expSum);
    checkOutput($sformatf("v%0d tot_last", idx), int'(TOT_LAST), v.expLast);
  endtask

  initial begin
    int busySeen;
    int doneSeen;
    int firstDone;

    //            n  th   tper mode thE  pE  hits sum   last
    vecs[0] = '{4,   5,   20,  0,   5,   20, 0,   0,    0};
    vecs[1] = '{3,   10,  30,  1,   10,  30, 3,   12,   4};
    vecs[2] = '{3,   0,   0,   0,   1,   4,  0,   0,    0};
    vecs[3] = '{5,   400, 410, 2,   400, 410, 5,  1023, 255};
    vecs[4] = '{2,   3,   4,   2,   3,   6,  2,   6,    3};
    vecs[5] = '{1,   7,   12,  1,   7,   12, 1,   4,    4};

    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    N_INJ = '0;
    T_HIGH = '0;
    T_PERIOD = '0;
    COMP = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    checkOutput("reset inj_out", int'(INJ_OUT), 0);
    checkOutput("reset busy", int'(BUSY), 0);
    checkOutput("reset done", int'(DONE), 0);
    checkOutput("reset hit_count", int'(HIT_COUNT), 0);
    checkOutput("reset tot_sum", int'(TOT_SUM), 0);
    checkOutput("reset tot_last", int'(TOT_LAST), 0);
    checkOutput("reset inj_count", int'(INJ_COUNT), 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, vecs[i]);
      tick();
    end

    // START with N_INJ=0 is ignored
    N_INJ = '0;
    T_HIGH = 16'd4;
    T_PERIOD = 16'd10;
    START = 1'b1;
    busySeen = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (BUSY === 1'b1 || INJ_OUT === 1'b1) busySeen++;
      START = 1'b0;
    end
    checkOutput("n0 start busy_cycles", busySeen, 0);

    // START together with ABORT in IDLE does nothing
    N_INJ = 16'd3;
    START = 1'b1;
    ABORT = 1'b1;
    busySeen = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (BUSY === 1'b1 || INJ_OUT === 1'b1) busySeen++;
      START = 1'b0;
      ABORT = 1'b0;
    end
    checkOutput("start_abort busy_cycles", busySeen, 0);

    // Abort during the second pulse: Th=4, Tl=6, P=10, COMP held high
    N_INJ = 16'd5;
    T_HIGH = 16'd4;
    T_PERIOD = 16'd10;
    COMP = 1'b1;
    START = 1'b1;
    doneSeen = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (DONE === 1'b1) doneSeen++;
      START = 1'b0;
    end
    checkOutput("abort pre inj_out", int'(INJ_OUT), 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checkOutput("abort inj_out", int'(INJ_OUT), 0);
    checkOutput("abort busy", int'(BUSY), 0);
    checkOutput("abort inj_count", int'(INJ_COUNT), 1);
    checkOutput("abort hit_count", int'(HIT_COUNT), 1);
    checkOutput("abort tot_last", int'(TOT_LAST), 4);
    checkOutput("abort tot_sum", int'(TOT_SUM), 4);
    COMP = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (DONE === 1'b1) doneSeen++;
    end
    checkOutput("abort done_cycles", doneSeen, 0);
    checkOutput("abort busy_after", int'(BUSY), 0);

    // START and config changes while BUSY: Th=2, Tl=4, P=6, N=2
    N_INJ = 16'd2;
    T_HIGH = 16'd2;
    T_PERIOD = 16'd6;
    START = 1'b1;
    firstDone = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 7) checkOutput("busy_start inj_c7", int'(INJ_OUT), 1);
      if (c == 9) checkOutput("busy_start inj_c9", int'(INJ_OUT), 0);
      if (DONE === 1'b1 && firstDone == 0) firstDone = c;
      START = (c == 3);
      if (c == 3) begin
        N_INJ = 16'd7;
        T_HIGH = 16'd9;
        T_PERIOD = 16'd50;
      end
    end
    checkOutput("busy_start done_cycle", firstDone, 13);
    checkOutput("busy_start inj_count", int'(INJ_COUNT), 2);
    checkOutput("busy_start busy_after", int'(BUSY), 0);

    // RESET during the second pulse's HIGH phase: Th=5, Tl=5, P=10
    N_INJ = 16'd3;
    T_HIGH = 16'd5;
    T_PERIOD = 16'd10;
    COMP = 1'b1;
    START = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      START = 1'b0;
    end
    checkOutput("rst_mid pre inj_count", int'(INJ_COUNT), 1);
    checkOutput("rst_mid pre tot_last", int'(TOT_LAST), 5);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    COMP = 1'b0;
    checkOutput("rst_mid inj_out", int'(INJ_OUT), 0);
    checkOutput("rst_mid busy", int'(BUSY), 0);
    checkOutput("rst_mid done", int'(DONE), 0);
    checkOutput("rst_mid hit_count", int'(HIT_COUNT), 0);
    checkOutput("rst_mid tot_sum", int'(TOT_SUM), 0);
    checkOutput("rst_mid tot_last", int'(TOT_LAST), 0);
    checkOutput("rst_mid inj_count", int'(INJ_COUNT), 0);
    applyStimulus(9, vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_inj_sequencer.md
# afe_inj_sequencer

Injection-scan controller for the AFE CPLD. It generates a programmable train of injection pulses on the injection line and measures each pulse's response: a synchronized comparator time-over-threshold (TOT) count and a hit flag. It accumulates hit count and TOT sum over the train and signals completion, so host firmware can run threshold or gain scans without toggling injection pulse by pulse over SPI. It sits between the SPI configuration registers and the analog front-end's injection/comparator pins.

## Interface
Parameters:
- `CNT_W`, 16: width of the injection count, timing fields and hit counter.
- `TOT_W`, 8: width of the per-pulse TOT counter, which saturates.
- `SUM_W`, 24: width of the TOT accumulator, which saturates.

Ports:
- `CLK`  in  1  system clock; all logic is on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  single-cycle request to begin a train; sampled only in IDLE.
- `ABORT`  in  1  stops the train; wins over all other events except `RESET`.
- `N_INJ`  in  CNT_W  number of pulses; 0 means START is ignored.
- `T_HIGH`  in  CNT_W  pulse high time in cycles; 0 is treated as 1.
- `T_PERIOD`  in  CNT_W  pulse period in cycles; effective low time is max(T_PERIOD−Th, 3).
- `COMP`  in  1  asynchronous comparator output.
- `INJ_OUT`  out  1  injection pulse, registered.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse when a train completes normally.
- `HIT_COUNT`  out  CNT_W  number of pulses with a hit.
- `TOT_SUM`  out  SUM_W  sum of TOT over hit pulses; saturates at all-ones.
- `TOT_LAST`  out  TOT_W  TOT of the most recently completed pulse (0 if it had no hit).
- `INJ_COUNT`  out  CNT_W  number of pulses completed so far.

## Operation
- Timing fields are latched when the train starts:
  - Th = max(T_HIGH, 1).
  - Tl = max(T_PERIOD − Th, 3).
  - P = Th + Tl.
- COMP passes through a 2-flop synchronizer to give `comp_s`.
- Measurement window: `INJ_OUT` delayed 2 cycles (`win`). This aligns the window with `comp_s`. Tl ≥ 3 guarantees the window closes before the pulse is evaluated.
- Per-pulse logic:
  - When `win`=1 and `comp_s`=1: `tot` increments, saturating at 2^TOT_W−1, and `hit` is set.
  - `tot` and `hit` clear at the start of each HIGH phase.
- States:
  - IDLE: INJ_OUT=0. On START with N_INJ≠0, latch N/Th/Tl, clear HIT_COUNT, TOT_SUM, TOT_LAST and INJ_COUNT, then go to HIGH.
  - HIGH: INJ_OUT=1 for Th cycles, then go to LOW.
  - LOW: INJ_OUT=0 for Tl cycles. In the last LOW cycle, evaluate the pulse:
    - INJ_COUNT += 1.
    - TOT_LAST ← tot if hit, else 0.
    - If hit: HIT_COUNT += 1 and TOT_SUM += tot (saturating).
    - Next state is HIGH if INJ_COUNT+1 < N, else FIN.
  - FIN: DONE=1 for one cycle, then go to IDLE.
- Boundary behaviour:
  - ABORT in any non-IDLE state: go to IDLE next cycle and force INJ_OUT=0. Results keep their partial values; the pulse in progress is not evaluated and DONE is not asserted.
  - START while BUSY is ignored. Config input changes while BUSY have no effect.
  - START and ABORT together in IDLE: ABORT wins and nothing starts.
  - RESET: state IDLE, and every output plus the internal counters, synchronizer and `win` pipeline go to 0.

## Timing
- START sampled at edge 0: INJ_OUT is high during cycles 1..Th, low during cycles Th+1..P.
- Pulse k (0-based) has its high phase at cycles kP+1 .. kP+Th.
- Pulse evaluation happens in cycle (k+1)P. Its results are visible from cycle (k+1)P+1.
- DONE is high in cycle N·P+1; BUSY falls in cycle N·P+2.
- A new START is accepted from cycle N·P+2.
- COMP-to-count latency is 2 cycles. A COMP pulse of m cycles fully inside the window adds m to TOT.

## Test plan
- Basic train: N=4, T_HIGH=5, T_PERIOD=20, COMP held 0 → 4 INJ pulses each 5 cycles high with period 20. DONE at cycle 81. HIT_COUNT=0, TOT_SUM=0, INJ_COUNT=4.
- Response measurement: N=3, Th=10, P=30, COMP high 4 cycles starting 2 cycles after each INJ rising edge → HIT_COUNT=3, TOT_LAST=4, TOT_SUM=12.
- Saturation and clamping: T_HIGH=0, T_PERIOD=0 → pulse 1 high, 3 low (P=4). Separately, Th=400 with COMP held high → TOT_LAST=255 per pulse, and TOT_SUM saturates when TOT_SUM is preloaded near its limit by a long run.
- Abort: ABORT during pulse 2 of N=5 → INJ_OUT=0 and BUSY=0 the next cycle, INJ_COUNT=1, no DONE.
- Ignored and conflicting requests:
  - START with N_INJ=0 → stays IDLE.
  - START while BUSY → no restart.
  - START together with ABORT in IDLE → stays IDLE.
- Reset mid-train: RESET during HIGH → all outputs 0 the next cycle. A following START gives a correct fresh train.
